// File: rtl/lp_filter_settle.sv
// ---------------------------------------------------------------------------
// lp_filter_settle
//
// First-order low-pass filter, time constant 8 ns * 2^tau per accepted
// sample. Shares the tau encoding with the high-pass filter so the two can
// split one signal into complementary LP/HP bands.
//
// Adds a sample strobe, a registered output with a valid pulse, bumpless
// preload on start and on tau change, and a settle flag.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   tau_i        [3:0] = shift, [5:4] != 0 selects bypass
//   in_i         signed input sample (R bits)
//   in_valid_i   sample strobe, may be held high every cycle
//   out_o        signed filtered output, registered (R bits)
//   out_valid_o  one-cycle pulse, one cycle after each accepted sample
//   settled_o    high while locked or in bypass
// ---------------------------------------------------------------------------
module lp_filter_settle #(
    parameter int R = 14,   // sample width
    parameter int S = 58,   // accumulator width, S >= R + 16 + 2
    parameter int K = 2     // settle length = 2^K * 2^sh samples
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          tau_i,
    input  logic signed [R-1:0] in_i,
    input  logic                in_valid_i,
    output logic signed [R-1:0] out_o,
    output logic                out_valid_o,
    output logic                settled_o
);

    localparam int CW = K + 16;   // settle counter width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              state_q;
    logic [5:0]          tau_q;
    logic signed [S-1:0] sum_q;
    logic signed [R-1:0] out_q;
    logic                out_valid_q;
    logic                settled_q;
    logic [CW-1:0]       cnt_q;

    // -----------------------------------------------------------------------
    // Datapath helpers
    // -----------------------------------------------------------------------
    logic [3:0]          sh;
    logic                byp;
    logic                tau_chg;
    logic signed [S:0]   sum_ext;
    logic signed [S:0]   in_ext;
    logic signed [S:0]   sum_wide;
    logic signed [S-1:0] sum_sat_d;
    logic signed [R-1:0] out_rec_d;
    logic signed [S-1:0] pre_in_d;
    logic signed [S-1:0] pre_out_d;
    logic [CW-1:0]       cnt_inc_d;
    logic [CW-1:0]       cnt_thr;

    always_comb begin
        sh      = tau_i[3:0];
        byp     = |tau_i[5:4];
        // tau_q is cleared in reset, so this only means something out of reset
        tau_chg = (tau_i != tau_q);

        // Recursion carried one bit wider than the accumulator so overflow
        // shows up in the top two bits and can be clamped instead of wrapping.
        sum_ext  = {sum_q[S-1], sum_q};
        in_ext   = {{(S+1-R){in_i[R-1]}}, in_i};
        sum_wide = sum_ext + in_ext - (sum_ext >>> sh);

        case (sum_wide[S:S-1])
            2'b01:   sum_sat_d = {1'b0, {(S-1){1'b1}}};
            2'b10:   sum_sat_d = {1'b1, {(S-1){1'b0}}};
            default: sum_sat_d = sum_wide[S-1:0];
        endcase

        // Arithmetic shift floors toward -inf; no rounding correction.
        out_rec_d = R'(sum_sat_d >>> sh);

        // Preload values: accumulator scaled so that sum >>> sh reproduces
        // the seed exactly, which is what makes the start/retune bumpless.
        pre_in_d  = {{(S-R){in_i[R-1]}}, in_i} <<< sh;
        pre_out_d = {{(S-R){out_q[R-1]}}, out_q} <<< sh;

        cnt_inc_d = cnt_q + CW'(1);
        cnt_thr   = (CW'(1) << (K + int'(sh))) - CW'(1);
    end

    // -----------------------------------------------------------------------
    // Control FSM and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tau_q       <= '0;
            sum_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            settled_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            tau_q       <= tau_i;
            out_valid_q <= 1'b0;

            if (byp) begin
                // Straight pass-through; accumulator left alone. A bypassed
                // sample leaves IDLE so that leaving bypass later preloads
                // from the output it produced.
                settled_q <= 1'b1;
                if (in_valid_i) begin
                    out_q       <= in_i;
                    out_valid_q <= 1'b1;
                    if (state_q == ST_IDLE) begin
                        state_q <= ST_SETTLE;
                    end
                end
            end else begin
                settled_q <= (state_q == ST_LOCKED);
                case (state_q)
                    ST_IDLE: begin
                        // tau changes here only update tau_q
                        settled_q <= 1'b0;
                        if (in_valid_i) begin
                            sum_q       <= pre_in_d;
                            out_q       <= in_i;
                            out_valid_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= ST_SETTLE;
                        end
                    end

                    ST_SETTLE, ST_LOCKED: begin
                        if (tau_chg) begin
                            // Retune: reseed from the held output; a sample
                            // arriving this cycle is dropped.
                            sum_q     <= pre_out_d;
                            cnt_q     <= '0;
                            state_q   <= ST_SETTLE;
                            settled_q <= 1'b0;
                        end else if (in_valid_i) begin
                            sum_q       <= sum_sat_d;
                            out_q       <= out_rec_d;
                            out_valid_q <= 1'b1;
                            if (state_q == ST_SETTLE) begin
                                cnt_q <= cnt_inc_d;
                                if (cnt_inc_d == cnt_thr) begin
                                    state_q   <= ST_LOCKED;
                                    settled_q <= 1'b1;
                                end
                            end
                        end
                    end

                    default: begin
                        state_q   <= ST_IDLE;
                        settled_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign settled_o   = settled_q;

endmodule
